// File: rtl/qbus_dma_master.sv
// -----------------------------------------------------------------------------
// qbus_dma_master
//
// Qbus DMA bus-master sequencer. It requests the bus with TDMR, takes the
// grant with TSACK, and runs one DATI (read) or DATO (write) cycle:
// address phase, then TSYNC, then DIN/DOUT, then it waits for RPLY. If RPLY
// does not arrive in time, it reports a non-existent-memory (NXM) error.
//
// Optional feature (compile-time macro):
//   DMA_BURST_EN - when defined, up to BURST_MAX transfers run under one
//                  grant while the device keeps its request high. When it
//                  is undefined, each grant carries exactly one transfer.
//
// Parameters:
//   ADDR_SETUP - clk cycles that TAL/TWTBT are driven before TSYNC
//   TIMEOUT    - clk cycles from TSYNC to wait for RPLY before NXM
//   BURST_MAX  - transfers per grant (only with DMA_BURST_EN)
//
// Ports:
//   clk            in   20 MHz clock
//   RINIT          in   synchronous active-high reset
//   dma_read_req   in   device requests a DATI (memory to device)
//   dma_write_req  in   device requests a DATO (device to memory)
//   dma_bus_master out  high while this block owns the bus
//   dma_complete   out  one-cycle pulse when a transfer finishes
//   dma_nxm        out  one-cycle pulse on reply timeout
//   RDMG           in   DMA grant
//   RSYNC          in   bus SYNC as received
//   RRPLY          in   bus RPLY, asynchronous (synchronized here)
//   TDMR           out  DMA request
//   TSACK          out  select acknowledge
//   TSYNC          out  master SYNC
//   TDIN           out  master DIN
//   TDOUT          out  master DOUT
//   TWTBT          out  write/byte, address phase of a DATO
//   addr_drive     out  enable the device's TAL onto the bus
//   data_drive     out  enable the device's TDL onto the bus
// -----------------------------------------------------------------------------
module qbus_dma_master #(
  parameter int ADDR_SETUP = 3,
  parameter int TIMEOUT    = 200,
  parameter int BURST_MAX  = 4
) (
  input  logic clk,
  input  logic RINIT,
  input  logic dma_read_req,
  input  logic dma_write_req,
  output logic dma_bus_master,
  output logic dma_complete,
  output logic dma_nxm,
  input  logic RDMG,
  input  logic RSYNC,
  input  logic RRPLY,
  output logic TDMR,
  output logic TSACK,
  output logic TSYNC,
  output logic TDIN,
  output logic TDOUT,
  output logic TWTBT,
  output logic addr_drive,
  output logic data_drive
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_ACQ  = 3'd2;
  localparam logic [2:0] S_ADDR = 3'd3;
  localparam logic [2:0] S_XFER = 3'd4;
  localparam logic [2:0] S_RELS = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  // One counter serves both the address-setup count and the reply timeout.
  localparam int CNT_W  = $clog2(TIMEOUT + ADDR_SETUP + 1);
  localparam int XCNT_W = $clog2(BURST_MAX + 1);
`ifdef DMA_BURST_EN
  localparam int XFERS_PER_GRANT = BURST_MAX;
`else
  localparam int XFERS_PER_GRANT = 1;
`endif

  logic [2:0]        state_q, state_d;
  logic              rply_meta_q, rply_meta_d;
  logic              rply_s_q, rply_s_d;
  logic              dir_wr_q, dir_wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XCNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [1:0]        settle_q, settle_d;
  logic              nxm_seen_q, nxm_seen_d;
  logic              bus_master_q, bus_master_d;
  logic              complete_q, complete_d;
  logic              nxm_q, nxm_d;
  logic              tdmr_q, tdmr_d;
  logic              tsack_q, tsack_d;
  logic              tsync_q, tsync_d;
  logic              tdin_q, tdin_d;
  logic              tdout_q, tdout_d;
  logic              twtbt_q, twtbt_d;
  logic              addr_drive_q, addr_drive_d;
  logic              data_drive_q, data_drive_d;
  logic              req_any;

  assign req_any = dma_read_req | dma_write_req;

  always_comb begin
    state_d      = state_q;
    rply_meta_d  = RRPLY;
    rply_s_d     = rply_meta_q;
    dir_wr_d     = dir_wr_q;
    cnt_d        = cnt_q;
    xfer_cnt_d   = xfer_cnt_q;
    settle_d     = (settle_q != 2'd0) ? settle_q - 2'd1 : 2'd0;
    nxm_seen_d   = nxm_seen_q;
    bus_master_d = bus_master_q;
    complete_d   = 1'b0;
    nxm_d        = 1'b0;
    tdmr_d       = tdmr_q;
    tsack_d      = tsack_q;
    tsync_d      = tsync_q;
    tdin_d       = tdin_q;
    tdout_d      = tdout_q;
    twtbt_d      = twtbt_q;
    addr_drive_d = addr_drive_q;
    data_drive_d = data_drive_q;

    case (state_q)
      S_IDLE: begin
        // settle_q holds off sampling while the device updates its word count.
        if (settle_q == 2'd0 && req_any) begin
          tdmr_d   = 1'b1;
          dir_wr_d = ~dma_read_req;  // read wins when both are high
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (RDMG) begin
          tdmr_d       = 1'b0;
          tsack_d      = 1'b1;
          bus_master_d = 1'b1;
          xfer_cnt_d   = '0;
          nxm_seen_d   = 1'b0;
          // A request withdrawn as the grant lands: acknowledge, then release.
          state_d      = req_any ? S_ACQ : S_DONE;
        end else if (!req_any) begin
          tdmr_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_ACQ: begin
        if (!RSYNC && !rply_s_q) begin
          addr_drive_d = 1'b1;
          twtbt_d      = dir_wr_q;
          cnt_d        = '0;
          state_d      = S_ADDR;
        end
      end
      S_ADDR: begin
        if (cnt_q == CNT_W'(ADDR_SETUP - 1)) begin
          addr_drive_d = 1'b0;
          twtbt_d      = 1'b0;
          tsync_d      = 1'b1;
          cnt_d        = '0;
          state_d      = S_XFER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_XFER: begin
        tdin_d       = ~dir_wr_q;
        tdout_d      = dir_wr_q;
        data_drive_d = dir_wr_q;
        cnt_d        = cnt_q + CNT_W'(1);
        // rply_s_d is the value rply_s takes this edge, so the pulse lines
        // up with the first cycle in which the synchronized reply is high.
        if (rply_s_d) begin
          complete_d = 1'b1;
          settle_d   = 2'd2;
          xfer_cnt_d = xfer_cnt_q + XCNT_W'(1);
          state_d    = S_RELS;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          nxm_d        = 1'b1;
          nxm_seen_d   = 1'b1;
          tdin_d       = 1'b0;
          tdout_d      = 1'b0;
          tsync_d      = 1'b0;
          data_drive_d = 1'b0;
          state_d      = S_DONE;
        end
      end
      S_RELS: begin
        tdin_d  = 1'b0;
        tdout_d = 1'b0;
        if (!rply_s_q) begin
          tsync_d      = 1'b0;
          data_drive_d = 1'b0;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        // Keep the grant for another word only after a good transfer and
        // while under the per-grant limit; otherwise release the bus.
        if (req_any && !nxm_seen_q && xfer_cnt_q != '0 &&
            xfer_cnt_q < XCNT_W'(XFERS_PER_GRANT)) begin
          if (settle_q == 2'd0) begin
            dir_wr_d = ~dma_read_req;
            state_d  = S_ACQ;
          end
        end else begin
          tsack_d      = 1'b0;
          bus_master_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RINIT) begin
      state_q      <= S_IDLE;
      rply_meta_q  <= 1'b0;
      rply_s_q     <= 1'b0;
      dir_wr_q     <= 1'b0;
      cnt_q        <= '0;
      xfer_cnt_q   <= '0;
      settle_q     <= 2'd0;
      nxm_seen_q   <= 1'b0;
      bus_master_q <= 1'b0;
      complete_q   <= 1'b0;
      nxm_q        <= 1'b0;
      tdmr_q       <= 1'b0;
      tsack_q      <= 1'b0;
      tsync_q      <= 1'b0;
      tdin_q       <= 1'b0;
      tdout_q      <= 1'b0;
      twtbt_q      <= 1'b0;
      addr_drive_q <= 1'b0;
      data_drive_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rply_meta_q  <= rply_meta_d;
      rply_s_q     <= rply_s_d;
      dir_wr_q     <= dir_wr_d;
      cnt_q        <= cnt_d;
      xfer_cnt_q   <= xfer_cnt_d;
      settle_q     <= settle_d;
      nxm_seen_q   <= nxm_seen_d;
      bus_master_q <= bus_master_d;
      complete_q   <= complete_d;
      nxm_q        <= nxm_d;
      tdmr_q       <= tdmr_d;
      tsack_q      <= tsack_d;
      tsync_q      <= tsync_d;
      tdin_q       <= tdin_d;
      tdout_q      <= tdout_d;
      twtbt_q      <= twtbt_d;
      addr_drive_q <= addr_drive_d;
      data_drive_q <= data_drive_d;
    end
  end

  assign dma_bus_master = bus_master_q;
  assign dma_complete   = complete_q;
  assign dma_nxm        = nxm_q;
  assign TDMR           = tdmr_q;
  assign TSACK          = tsack_q;
  assign TSYNC          = tsync_q;
  assign TDIN           = tdin_q;
  assign TDOUT          = tdout_q;
  assign TWTBT          = twtbt_q;
  assign addr_drive     = addr_drive_q;
  assign data_drive     = data_drive_q;

endmodule

// File: tb/tb_qbus_dma_master.sv
// -----------------------------------------------------------------------------
// tb_qbus_dma_master
//
// Self-checking bench for qbus_dma_master. The bench plays the device (word
// count, request lines), the bus arbiter (RDMG after a chosen delay, a
// previous master holding RSYNC) and the slave (RRPLY a chosen number of
// cycles after TSYNC). Bus events are time-stamped in clock ticks and the
// expected timing is computed from the protocol rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_qbus_dma_master;

  localparam int ADDR_SETUP = 3;
  localparam int TIMEOUT    = 200;
  localparam int BURST_MAX  = 4;
`ifdef DMA_BURST_EN
  localparam int PER_GRANT = BURST_MAX;
`else
  localparam int PER_GRANT = 1;
`endif

  logic clk = 1'b0;
  always #25 clk = ~clk;

  logic rinit, rd_req, wr_req, rdmg, rsync, rrply;
  logic bm, cmpl, nxm, tdmr, tsack, tsync, tdin, tdout, twtbt, addr_drv, data_drv;
  logic [10:0] outs;
  assign outs = {bm, cmpl, nxm, tdmr, tsack, tsync, tdin, tdout, twtbt, addr_drv, data_drv};

  qbus_dma_master #(.ADDR_SETUP(ADDR_SETUP), .TIMEOUT(TIMEOUT), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .RINIT(rinit),
    .dma_read_req(rd_req), .dma_write_req(wr_req),
    .dma_bus_master(bm), .dma_complete(cmpl), .dma_nxm(nxm),
    .RDMG(rdmg), .RSYNC(rsync), .RRPLY(rrply),
    .TDMR(tdmr), .TSACK(tsack), .TSYNC(tsync), .TDIN(tdin), .TDOUT(tdout),
    .TWTBT(twtbt), .addr_drive(addr_drv), .data_drive(data_drv)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Scenario knobs
  bit bus_auto, reply_en, exp_wr;
  int gnt_dly, rply_dly, rsync_hold, rsync_until, words;

  // Event record, in ticks
  int cyc;
  int t_tdmr, t_gnt, t_addr_first, addr_len, twtbt_bad, t_sync, t_strobe;
  int t_cmpl, n_cmpl, t_nxm, n_nxm, t_rply, t_rply_fall, t_sync_fall, t_bm_fall;
  int t_dd_rise, t_dd_fall, n_grants, n_tdin, n_tdout, n_sync, t_rsync_fall, outs_nxm1;
  logic p_tdmr, p_tsack, p_addr, p_tsync, p_strobe, p_dd, p_bm, p_cmpl, p_nxm;

  task automatic clear_stats();
    t_tdmr = -1; t_gnt = -1; t_addr_first = -1; addr_len = 0; twtbt_bad = 0;
    t_sync = -1; t_strobe = -1; t_cmpl = -1; n_cmpl = 0; t_nxm = -10; n_nxm = 0;
    t_rply = -1; t_rply_fall = -1; t_sync_fall = -1; t_bm_fall = -1;
    t_dd_rise = -1; t_dd_fall = -1; n_grants = 0; n_tdin = 0; n_tdout = 0;
    n_sync = 0; t_rsync_fall = -1; outs_nxm1 = -1;
  endtask

  // One clock: sample at the falling edge, check bus rules, record events,
  // then let the device/arbiter/slave models drive the next inputs.
  task automatic tick();
    @(negedge clk);
    cyc++;
    check_eq("one_strobe", int'(tdin & tdout), 0);
    check_eq("strobe_in_sync", int'((tdin | tdout) & ~tsync), 0);
    check_eq("pulse_excl", int'(cmpl & nxm), 0);
    check_eq("pulse_len", int'((cmpl & p_cmpl) | (nxm & p_nxm)), 0);
    check_eq("twtbt_addr", int'(twtbt & ~addr_drv), 0);

    if (tdmr && !p_tdmr) t_tdmr = cyc;
    if (tsack && !p_tsack) begin n_grants++; t_gnt = cyc; end
    if (addr_drv && !p_addr) t_addr_first = cyc;
    if (addr_drv) begin addr_len++; if (twtbt !== exp_wr) twtbt_bad++; end
    if (tsync && !p_tsync) begin t_sync = cyc; n_sync++; end
    if (!tsync && p_tsync) t_sync_fall = cyc;
    if ((tdin | tdout) && !p_strobe) t_strobe = cyc;
    if (tdin) n_tdin++;
    if (tdout) n_tdout++;
    if (data_drv && !p_dd) t_dd_rise = cyc;
    if (!data_drv && p_dd) t_dd_fall = cyc;
    if (!bm && p_bm) t_bm_fall = cyc;
    if (cyc == t_nxm + 1) outs_nxm1 = int'(outs);
    if (cmpl) begin
      n_cmpl++; t_cmpl = cyc;
      if (words > 0) words--;
      if (words == 0) begin rd_req = 1'b0; wr_req = 1'b0; end
    end
    if (nxm) begin
      n_nxm++; t_nxm = cyc; words = 0; rd_req = 1'b0; wr_req = 1'b0;
    end

    if (bus_auto) begin
      if (rsync && cyc >= rsync_until) begin rsync = 1'b0; t_rsync_fall = cyc; end
      if (tsack) rdmg = 1'b0;
      else if (tdmr && !rdmg && cyc - t_tdmr >= gnt_dly) begin
        rdmg = 1'b1;
        rsync_until = cyc + rsync_hold;
        if (rsync_hold > 0) rsync = 1'b1;
        else t_rsync_fall = cyc;
      end
      if (rrply && !(tdin | tdout)) begin
        rrply = 1'b0; t_rply_fall = cyc;
      end else if (!rrply && reply_en && (tdin | tdout) && cyc - t_sync >= rply_dly) begin
        rrply = 1'b1; t_rply = cyc;
      end
    end

    p_tdmr = tdmr; p_tsack = tsack; p_addr = addr_drv; p_tsync = tsync;
    p_strobe = tdin | tdout; p_dd = data_drv; p_bm = bm; p_cmpl = cmpl; p_nxm = nxm;
  endtask

  task automatic start_req(input bit rd, input bit wr, input int nwords);
    words  = nwords;
    exp_wr = !rd && wr;
    rd_req = rd;
    wr_req = wr;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (words == 0 && !bm && !tdmr && !rrply) done = 1'b1;
    end
    check_eq("idle_reached", int'(done), 1);
    repeat (3) tick();
  endtask

  task automatic check_single(input bit wr, input bit rep);
    check_eq("grants", n_grants, 1);
    check_eq("tdmr_to_tsack", t_gnt - t_tdmr, gnt_dly + 1);
    check_eq("acq_wait", int'(t_addr_first > t_rsync_fall), 1);
    check_eq("addr_len", addr_len, ADDR_SETUP);
    check_eq("twtbt_dir", twtbt_bad, 0);
    check_eq("sync_after_addr", t_sync - t_addr_first, ADDR_SETUP);
    check_eq("strobe_lat", t_strobe - t_sync, 1);
    check_eq("tdin_used", int'(n_tdin > 0), int'(!wr));
    check_eq("tdout_used", int'(n_tdout > 0), int'(wr));
    if (rep) begin
      check_eq("n_cmpl", n_cmpl, 1);
      check_eq("n_nxm", n_nxm, 0);
      check_eq("rply_at", t_rply - t_sync, rply_dly);
      check_eq("cmpl_lat", t_cmpl - t_rply, 2);
      check_eq("rels_lat", t_sync_fall - t_rply_fall, 3);
      check_eq("bm_fall", t_bm_fall - t_sync_fall, 1);
      if (wr) begin
        check_eq("dd_rise", t_dd_rise, t_strobe);
        check_eq("dd_fall", t_dd_fall, t_sync_fall);
      end else begin
        check_eq("dd_read", t_dd_rise, -1);
      end
    end else begin
      check_eq("nxm_n", n_nxm, 1);
      check_eq("nxm_no_cmpl", n_cmpl, 0);
      check_eq("nxm_at", t_nxm - t_sync, TIMEOUT);
      check_eq("nxm_sync_off", t_sync_fall, t_nxm);
      check_eq("nxm_outs", outs_nxm1, 0);
    end
  endtask

  task automatic run_one(input bit rd, input bit wr, input int gd, input int rdl,
                         input int hold, input bit rep);
    gnt_dly = gd; rply_dly = rdl; rsync_hold = hold; reply_en = rep; bus_auto = 1'b1;
    clear_stats();
    start_req(rd, wr, 1);
    wait_idle(TIMEOUT + 200);
    check_single(!rd && wr, rep);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit rd, wr, rep;
    int sel, exp_grants;
    bit hit;
    rinit = 1'b1; rd_req = 1'b0; wr_req = 1'b0; rdmg = 1'b0; rsync = 1'b0; rrply = 1'b0;
    bus_auto = 1'b0; reply_en = 1'b1; exp_wr = 1'b0; words = 0;
    gnt_dly = 0; rply_dly = 1; rsync_hold = 0; rsync_until = 0; cyc = 0;
    p_tdmr = 0; p_tsack = 0; p_addr = 0; p_tsync = 0; p_strobe = 0;
    p_dd = 0; p_bm = 0; p_cmpl = 0; p_nxm = 0;
    clear_stats();

    repeat (3) tick();
    check_eq("reset_outs", int'(outs), 0);
    rinit = 1'b0;
    repeat (2) tick();

    // Read: grant 5 cycles after TDMR, reply 10 cycles after TSYNC
    run_one(1'b1, 1'b0, 5, 10, 0, 1'b1);
    // Write with reply, previous master still holding SYNC briefly
    run_one(1'b0, 1'b1, 2, 4, 2, 1'b1);
    // No reply: NXM
    run_one(1'b1, 1'b0, 0, 1, 0, 1'b0);
    // Both requests: read wins
    run_one(1'b1, 1'b1, 3, 6, 1, 1'b1);

    // Request withdrawn before grant
    clear_stats();
    bus_auto = 1'b0;
    start_req(1'b1, 1'b0, 1);
    repeat (3) tick();
    check_eq("drop_tdmr_up", int'(tdmr), 1);
    rd_req = 1'b0; words = 0;
    tick();
    check_eq("drop_tdmr_down", int'(tdmr), 0);
    repeat (6) tick();
    check_eq("drop_no_sync", n_sync, 0);
    check_eq("drop_no_grant", n_grants, 0);

    // Request withdrawn in the same cycle the grant arrives
    clear_stats();
    start_req(1'b1, 1'b0, 1);
    repeat (3) tick();
    rd_req = 1'b0; words = 0; rdmg = 1'b1;
    tick();
    check_eq("late_drop_tsack", int'(tsack), 1);
    check_eq("late_drop_tdmr", int'(tdmr), 0);
    rdmg = 1'b0;
    tick();
    check_eq("late_drop_tsack_off", int'(tsack), 0);
    check_eq("late_drop_bm_off", int'(bm), 0);
    repeat (5) tick();
    check_eq("late_drop_no_sync", n_sync, 0);
    check_eq("late_drop_grants", n_grants, 1);

    // Reset in the middle of a data transfer
    clear_stats();
    gnt_dly = 1; rply_dly = 30; rsync_hold = 0; reply_en = 1'b1; bus_auto = 1'b1;
    start_req(1'b1, 1'b0, 1);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick();
      hit = tsync && (tdin || tdout);
    end
    check_eq("rst_reached_xfer", int'(hit), 1);
    rinit = 1'b1; bus_auto = 1'b0; rrply = 1'b0; rdmg = 1'b0; rsync = 1'b0;
    rd_req = 1'b0; wr_req = 1'b0; words = 0;
    tick();
    check_eq("rst_outs_next", int'(outs), 0);
    tick();
    check_eq("rst_outs_hold", int'(outs), 0);
    check_eq("rst_no_cmpl", n_cmpl, 0);
    check_eq("rst_no_nxm", n_nxm, 0);
    rinit = 1'b0;
    repeat (3) tick();
    run_one(1'b0, 1'b1, 1, 5, 0, 1'b1);

    // Randomized single transfers
    for (int k = 0; k < 12; k++) begin
      sel = $urandom_range(0, 2);
      rd  = (sel != 1);
      wr  = (sel != 0);
      rep = ($urandom_range(0, 4) != 0);
      run_one(rd, wr, $urandom_range(0, 8), $urandom_range(1, 15), $urandom_range(0, 3), rep);
    end

    // Six-word block transfer
    clear_stats();
    gnt_dly = 2; rply_dly = 3; rsync_hold = 0; reply_en = 1'b1; bus_auto = 1'b1;
    start_req(1'b0, 1'b1, 6);
    wait_idle(3000);
    exp_grants = (6 + PER_GRANT - 1) / PER_GRANT;
    check_eq("block_cmpl", n_cmpl, 6);
    check_eq("block_syncs", n_sync, 6);
    check_eq("block_grants", n_grants, exp_grants);
    check_eq("block_no_nxm", n_nxm, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/qbus_dma_master.md
QBUS_DMA_MASTER -- requirements
Module: qbus_dma_master

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_SETUP, 3: clk cycles of TAL/TWTBT drive before TSYNC.
- TIMEOUT, 200: clk cycles (10 us) waiting for RRPLY before NXM.
- BURST_MAX, 4: transfers per grant, used only when burst is enabled.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: 20 MHz clock.
- RINIT, in, 1: synchronous active-high reset.
- dma_read_req, in, 1: device requests a DATI (memory to device).
- dma_write_req, in, 1: device requests a DATO (device to memory).
- dma_bus_master, out, 1: high while this block owns the bus.
- dma_complete, out, 1: one-cycle pulse when a transfer finishes.
- dma_nxm, out, 1: one-cycle pulse on reply timeout.
- RDMG, in, 1: DMA grant in.
- RSYNC, in, 1: bus SYNC as received.
- RRPLY, in, 1: bus RPLY, asynchronous.
- TDMR, out, 1: DMA request.
- TSACK, out, 1: select acknowledge.
- TSYNC, out, 1: master SYNC.
- TDIN, out, 1: master DIN.
- TDOUT, out, 1: master DOUT.
- TWTBT, out, 1: write/byte, asserted during the address phase for DATO.
- addr_drive, out, 1: enable the device's TAL onto the bus.
- data_drive, out, 1: enable the device's TDL onto the bus.

REQ-003 The block SHALL use the single clock clk; reset RINIT is synchronous and active-high.

Function
REQ-004 RRPLY SHALL pass through a 2-flop synchronizer; rply_s denotes the synchronized value.

REQ-005 The state machine SHALL have the states IDLE, REQ, ACQ, ADDR, XFER, RELS, DONE.

REQ-006 IDLE: if (dma_read_req | dma_write_req), assert TDMR and go to REQ. The direction SHALL be latched at this point; read wins if both requests are high.

REQ-007 REQ: on RDMG=1, assert TSACK and negate TDMR in the same cycle, assert dma_bus_master, then go to ACQ.

REQ-008 ACQ: wait for RSYNC=0 and rply_s=0 (previous master finished), then go to ADDR. addr_drive SHALL go high on entry to ADDR; TWTBT SHALL equal the latched write direction.

REQ-009 ADDR: hold for exactly ADDR_SETUP cycles, then assert TSYNC, negate addr_drive and TWTBT, and go to XFER.
- DATO: data_drive and TDOUT SHALL assert on the cycle after TSYNC.
- DATI: TDIN SHALL assert on the cycle after TSYNC.

REQ-010 XFER: on the first cycle with rply_s=1, pulse dma_complete, then negate TDIN/TDOUT on the next cycle and go to RELS.

REQ-011 RELS: wait for rply_s=0, then negate TSYNC and data_drive and go to DONE.

REQ-012 DONE: negate TSACK and dma_bus_master, then return to IDLE. Requests SHALL NOT be sampled in IDLE until 2 cycles after dma_complete, because the device updates WC after the pulse.

REQ-013 The timeout counter SHALL start at TSYNC assertion. If it reaches TIMEOUT in XFER with rply_s=0:
- pulse dma_nxm (dma_complete stays low);
- negate TDIN, TDOUT, TSYNC, data_drive;
- go to DONE.

REQ-014 If the request drops while in REQ before grant: negate TDMR and return to IDLE. If RDMG arrives in the same cycle the request drops: take the grant, assert TSACK for one cycle, and release without a bus cycle.

REQ-015 dma_complete and dma_nxm SHALL be mutually exclusive and never high for more than 1 cycle.

REQ-016 At most one of TDIN/TDOUT SHALL be high at any time; TDIN/TDOUT SHALL be high only while TSYNC is high.

Reset
REQ-017 On RINIT=1:
- every output SHALL be 0 on the next clk edge;
- the state SHALL be IDLE;
- the counters and synchronizer SHALL clear.
This holds in every state, including mid-transfer; no completion pulse SHALL be generated.

Configuration
REQ-018 Macro DMA_BURST_EN.
- Defined: from DONE, if a request is still high, no NXM occurred, and fewer than BURST_MAX transfers have run under this grant, go to ACQ keeping TSACK. The 2-cycle settle of REQ-012 still applies before re-sampling.
- Undefined: exactly one transfer per grant.

Verification
REQ-019 Read, RDMG after 5 cycles, RRPLY 10 cycles after TSYNC:
- TDMR high → TSACK.
- addr_drive high for 3 cycles, then TSYNC, then TDIN.
- Exactly one dma_complete, 2 cycles after RRPLY rises.
- Bus released after RRPLY falls.

REQ-020 Write with RRPLY asserted:
- TWTBT=1 during the address phase.
- data_drive spans TDOUT through TSYNC negation.
- One dma_complete.
- TDIN never asserted.

REQ-021 No RRPLY: dma_nxm pulses exactly 200 cycles after TSYNC, with no dma_complete and all outputs 0 by DONE+1.

REQ-022 RINIT asserted in XFER: all outputs 0 on the next edge, no pulses, and a new request is then served normally.

REQ-023 Both requests high: a DATI is performed. A request dropped before RDMG: TDMR falls and there is no bus cycle.

REQ-024 DMA_BURST_EN defined, request held for 6 words: 4 transfers under one TSACK, release, re-request, then 2 more transfers. Undefined: 6 separate grants.
